// File: rtl/axi_sram_slave_pkg.sv
// Shared constants for the AXI3 SRAM slave: burst codes, response codes,
// FSM state encodings and the per-beat address step helper.
package axi_sram_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // IDLE is all-zero so the debug state reads 0 in reset like every other output.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_LAT  = 3'd2;
    localparam logic [2:0] ST_RD_RESP = 3'd3;
    localparam logic [2:0] ST_WR_DATA = 3'd4;
    localparam logic [2:0] ST_WR_RESP = 3'd5;

    // Bytes per beat; sizes wider than the 32-bit bus are clamped to 4 bytes.
    function automatic logic [31:0] beat_step(input logic [2:0] size);
        beat_step = (size > 3'd2) ? 32'd4 : (32'd1 << size);
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 32-bit channel bundle between an AXI master and the SRAM slave.
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where both valid and ready are high; once valid is raised the source
// holds it and its payload unchanged until that edge, and valid never
// depends combinationally on ready.
interface axi_sram_slave_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next-beat byte address for FIXED/INCR bursts; shared by read and write paths.
// Any burst code other than FIXED advances like INCR, wrapping at 32 bits.
module axi_burst_addr_gen
    import axi_sram_slave_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    assign next_addr = (burst == BURST_FIXED) ? addr : addr + beat_step(size);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving one transaction at a time from a 1-cycle-latency
// single-port SRAM. Writes win over a simultaneous read request so a read
// queued behind a write always observes the written data.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    axi_sram_slave_if.slave       bus,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [2:0]            dbg_state
);

    logic [2:0]  state_q, state_d;
    logic        run_q;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] addr_next;
    logic        last_beat;
    logic        wr_beat;
    logic        in_idle;
    logic        in_rd_resp;
    logic        in_wr_resp;
    logic        unused_bits;

    axi_burst_addr_gen u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .burst     (burst_q),
        .next_addr (addr_next)
    );

    // wid and the upper length bits carry no meaning for a 16-beat, in-order slave.
    assign unused_bits = ^{bus.wid, bus.arlen[7:4], bus.awlen[7:4]};

    assign last_beat  = (beat_cnt_q == len_q);
    assign in_idle    = (state_q == ST_IDLE);
    assign in_rd_resp = (state_q == ST_RD_RESP);
    assign in_wr_resp = (state_q == ST_WR_RESP);
    assign wr_beat    = (state_q == ST_WR_DATA) && bus.wvalid;

    // Channel outputs are decoded from registered state; only arready looks at awvalid.
    assign bus.awready = in_idle && run_q;
    assign bus.arready = in_idle && run_q && !bus.awvalid;
    assign bus.wready  = (state_q == ST_WR_DATA);
    assign bus.rvalid  = in_rd_resp;
    assign bus.rlast   = in_rd_resp && last_beat;
    assign bus.rid     = id_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = RESP_OKAY;
    assign bus.bvalid  = in_wr_resp;
    assign bus.bid     = id_q;
    assign bus.bresp   = (in_wr_resp && err_q) ? RESP_SLVERR : RESP_OKAY;

    // SRAM port: reads issue from RD_REQ, writes go out in the same cycle as the W beat.
    assign ram_en    = (state_q == ST_RD_REQ) || wr_beat;
    assign ram_we    = wr_beat ? bus.wstrb : 4'h0;
    assign ram_addr  = addr_q[ADDR_WIDTH+1:2];
    assign ram_wdata = wr_beat ? bus.wdata : 32'h0;
    assign dbg_state = state_q;

    // Transaction FSM and the per-transaction context registers.
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        beat_cnt_d = beat_cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (run_q && bus.awvalid) begin
                    id_d       = bus.awid;
                    addr_d     = bus.awaddr;
                    len_d      = bus.awlen[3:0];
                    size_d     = bus.awsize;
                    burst_d    = bus.awburst;
                    beat_cnt_d = 4'd0;
                    state_d    = ST_WR_DATA;
                end else if (run_q && bus.arvalid) begin
                    id_d       = bus.arid;
                    addr_d     = bus.araddr;
                    len_d      = bus.arlen[3:0];
                    size_d     = bus.arsize;
                    burst_d    = bus.arburst;
                    beat_cnt_d = 4'd0;
                    state_d    = ST_RD_REQ;
                end
            end
            ST_RD_REQ: state_d = ST_RD_LAT;
            ST_RD_LAT: begin
                rdata_d = ram_rdata;
                state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                if (bus.rready) begin
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d     = addr_next;
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        state_d    = ST_RD_REQ;
                    end
                end
            end
            ST_WR_DATA: begin
                if (bus.wvalid) begin
                    addr_d     = addr_next;
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    // The beat count ends the burst; a misplaced wlast is only reported.
                    if (bus.wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = ST_WR_RESP;
                    end
                end
            end
            ST_WR_RESP: begin
                if (bus.bready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and context flops; run_q keeps the address channels closed for one cycle after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            id_q       <= 4'd0;
            addr_q     <= 32'd0;
            len_q      <= 4'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            beat_cnt_q <= 4'd0;
            rdata_q    <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= 1'b1;
            id_q       <= id_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            beat_cnt_q <= beat_cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: a table of single-beat writes/reads with
// hand-computed results, then hand-written burst, arbitration, wlast-error
// and mid-flight reset sequences.
module tb_axi_sram_slave;
    import axi_sram_slave_pkg::*;

    localparam int AW = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic [2:0]    dbg_state;

    axi_sram_slave_if bus ();

    axi_sram_slave #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .dbg_state (dbg_state)
    );

    // Synchronous SRAM with byte enables and 1-cycle read latency.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_wdata[i*8 +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.arready, bus.awready, bus.wready, bus.rvalid, bus.rlast, bus.rid,
                 bus.rdata, bus.rresp, bus.bvalid, bus.bid, bus.bresp,
                 ram_en, ram_we, ram_addr, ram_wdata, dbg_state};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                             input int len, input logic [1:0] burst, input logic [31:0] data0,
                             input logic [3:0] strb, input bit early_wlast,
                             input logic [1:0] exp_resp, input logic [15:0] word0);
        int t;
        bus.awid = id; bus.awaddr = addr; bus.awsize = size; bus.awlen = 8'(len);
        bus.awburst = burst; bus.awvalid = 1'b1;
        #1;
        t = 0;
        while (!bus.awready && t < 50) begin step(); t++; end
        chk("aw_ready", 32'(bus.awready), 32'd1);
        step();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = data0 + 32'(b);
            bus.wstrb  = strb;
            bus.wlast  = early_wlast ? (b == 0 || b == len) : (b == len);
            #1;
            t = 0;
            while (!bus.wready && t < 50) begin step(); t++; end
            chk("w_ready", 32'(bus.wready), 32'd1);
            chk("ram_en_wr", 32'(ram_en), 32'd1);
            chk("ram_we", 32'(ram_we), 32'(strb));
            chk("ram_addr_wr", 32'(ram_addr),
                32'(word0) + ((burst == BURST_FIXED) ? 32'd0 : 32'(b)));
            chk("ram_wdata", ram_wdata, data0 + 32'(b));
            step();
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 50) begin step(); t++; end
        chk("b_valid", 32'(bus.bvalid), 32'd1);
        chk("b_resp", 32'(bus.bresp), 32'(exp_resp));
        chk("b_id", 32'(bus.bid), 32'(id));
        step();
        bus.bready = 1'b0;
    endtask

    // Expected beat data must already be queued in exp_q.
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size,
                            input int len, input logic [1:0] burst, input bit toggle);
        int t;
        int n;
        logic [31:0] exp;
        bus.arid = id; bus.araddr = addr; bus.arsize = size; bus.arlen = 8'(len);
        bus.arburst = burst; bus.arvalid = 1'b1;
        bus.rready = !toggle;
        #1;
        t = 0;
        while (!bus.arready && t < 50) begin step(); t++; end
        chk("ar_ready", 32'(bus.arready), 32'd1);
        step();
        bus.arvalid = 1'b0;
        n = 1;
        while (!bus.rvalid && n < 50) begin step(); n++; end
        chk("r_latency", 32'(n), 32'd3);
        for (int b = 0; b <= len; b++) begin
            t = 0;
            while (!bus.rvalid && t < 50) begin step(); t++; end
            chk("r_valid", 32'(bus.rvalid), 32'd1);
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else begin
                exp = 32'hxxxxxxxx;
                chk("exp_q_underflow", 32'd1, 32'd0);
            end
            if (toggle) begin
                step();
                chk("r_hold_valid", 32'(bus.rvalid), 32'd1);
                chk("r_hold_data", bus.rdata, exp);
                chk("r_hold_id", 32'(bus.rid), 32'(id));
                bus.rready = 1'b1;
                #1;
            end
            chk("r_data", bus.rdata, exp);
            chk("r_last", 32'(bus.rlast), 32'(b == len));
            chk("r_id", 32'(bus.rid), 32'(id));
            chk("r_resp", 32'(bus.rresp), 32'(RESP_OKAY));
            step();
            if (toggle) bus.rready = 1'b0;
        end
        bus.rready = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          is_wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        logic [15:0] word;   // expected SRAM word index of a write
    } vec_t;

    vec_t vecs [13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 4'h3, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 4'hF, 16'h0040};
        vecs[1]  = '{1'b0, 4'h5, 32'h0000_0100, 3'd2, 32'hDEAD_BEEF, 4'h0, 16'h0000};
        vecs[2]  = '{1'b1, 4'h1, 32'h0000_0103, 3'd0, 32'h1100_0000, 4'h8, 16'h0040};
        vecs[3]  = '{1'b0, 4'h2, 32'h0000_0100, 3'd2, 32'h11AD_BEEF, 4'h0, 16'h0000};
        vecs[4]  = '{1'b1, 4'h7, 32'h0000_0104, 3'd2, 32'h0000_0000, 4'hF, 16'h0041};
        vecs[5]  = '{1'b1, 4'h7, 32'h0000_0104, 3'd2, 32'h1234_5678, 4'h3, 16'h0041};
        vecs[6]  = '{1'b0, 4'h9, 32'h0000_0104, 3'd2, 32'h0000_5678, 4'h0, 16'h0000};
        vecs[7]  = '{1'b1, 4'hA, 32'h0000_0108, 3'd2, 32'hA0A0_A0A0, 4'hF, 16'h0042};
        vecs[8]  = '{1'b1, 4'hB, 32'h0000_0108, 3'd2, 32'hFFFF_FFFF, 4'h0, 16'h0042};
        vecs[9]  = '{1'b0, 4'hC, 32'h0000_0108, 3'd2, 32'hA0A0_A0A0, 4'h0, 16'h0000};
        vecs[10] = '{1'b1, 4'hF, 32'h0004_0110, 3'd2, 32'hA5A5_A5A5, 4'hF, 16'h0044};
        vecs[11] = '{1'b0, 4'h0, 32'h0000_0110, 3'd2, 32'hA5A5_A5A5, 4'h0, 16'h0000};
        vecs[12] = '{1'b1, 4'hE, 32'h0000_0500, 3'd2, 32'h0BAD_F00D, 4'hF, 16'h0140};

        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;

        // Reset: all outputs low, address channels open one cycle after release.
        resetn = 1'b1;
        #3 resetn = 1'b0;
        #1;
        chk("reset_outputs_zero", 32'(any_out()), 32'd0);
        step();
        step();
        resetn = 1'b1;
        #1;
        chk("run_gate_awready", 32'(bus.awready), 32'd0);
        step();
        chk("post_reset_awready", 32'(bus.awready), 32'd1);
        chk("post_reset_arready", 32'(bus.arready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].id, vecs[i].addr, vecs[i].size, 0, BURST_INCR,
                          vecs[i].data, vecs[i].strb, 1'b0, RESP_OKAY, vecs[i].word);
            end else begin
                exp_q.push_back(vecs[i].data);
                axi_read(vecs[i].id, vecs[i].addr, vecs[i].size, 0, BURST_INCR, 1'b0);
            end
        end

        // 4-beat INCR burst at 0x200 (words 0x80..0x83), read back with rready toggling.
        axi_write(4'h2, 32'h200, 3'd2, 3, BURST_INCR, 32'h1000_0000, 4'hF, 1'b0, RESP_OKAY, 16'h0080);
        for (int b = 0; b < 4; b++) exp_q.push_back(32'h1000_0000 + 32'(b));
        axi_read(4'h4, 32'h200, 3'd2, 3, BURST_INCR, 1'b1);

        // Simultaneous AW and AR: write wins, read then sees the new data.
        bus.arid = 4'h6; bus.araddr = 32'h300; bus.arsize = 3'd2; bus.arlen = 8'd0;
        bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        bus.awid = 4'h4; bus.awaddr = 32'h300; bus.awsize = 3'd2; bus.awlen = 8'd0;
        bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
        #1;
        chk("arb_awready", 32'(bus.awready), 32'd1);
        chk("arb_arready", 32'(bus.arready), 32'd0);
        axi_write(4'h4, 32'h300, 3'd2, 0, BURST_INCR, 32'hCAFE_F00D, 4'hF, 1'b0, RESP_OKAY, 16'h00C0);
        exp_q.push_back(32'hCAFE_F00D);
        axi_read(4'h6, 32'h300, 3'd2, 0, BURST_INCR, 1'b0);

        // W beats presented before AW are not accepted.
        bus.wvalid = 1'b1; bus.wdata = 32'h9999_9999; bus.wstrb = 4'hF; bus.wlast = 1'b1;
        step();
        chk("w_before_aw_wready", 32'(bus.wready), 32'd0);
        chk("w_before_aw_ram_en", 32'(ram_en), 32'd0);
        bus.wvalid = 1'b0; bus.wlast = 1'b0;

        // Early wlast on a 2-beat burst: both beats land, SLVERR; next burst is clean.
        axi_write(4'h8, 32'h400, 3'd2, 1, BURST_INCR, 32'h5555_0000, 4'hF, 1'b1, RESP_SLVERR, 16'h0100);
        axi_write(4'h9, 32'h408, 3'd2, 0, BURST_INCR, 32'h6666_0000, 4'hF, 1'b0, RESP_OKAY, 16'h0102);
        exp_q.push_back(32'h5555_0000);
        exp_q.push_back(32'h5555_0001);
        axi_read(4'h1, 32'h400, 3'd2, 1, BURST_INCR, 1'b0);
        // FIXED burst re-reads the same word on every beat.
        exp_q.push_back(32'h5555_0000);
        exp_q.push_back(32'h5555_0000);
        axi_read(4'h3, 32'h400, 3'd2, 1, BURST_FIXED, 1'b0);

        // Reset while a read response is pending.
        bus.arid = 4'h3; bus.araddr = 32'h100; bus.arsize = 3'd2; bus.arlen = 8'd0;
        bus.arburst = BURST_INCR; bus.arvalid = 1'b1; bus.rready = 1'b0;
        step();
        bus.arvalid = 1'b0;
        for (int t = 0; t < 10 && !bus.rvalid; t++) step();
        chk("rd_abort_rvalid_pre", 32'(bus.rvalid), 32'd1);
        chk("rd_abort_state_pre", 32'(dbg_state), 32'(ST_RD_RESP));
        resetn = 1'b0;
        #1;
        chk("rd_abort_outputs_zero", 32'(any_out()), 32'd0);
        step();
        resetn = 1'b1;
        #1;
        chk("rd_abort_run_gate", 32'(bus.arready), 32'd0);
        step();
        chk("rd_abort_arready_back", 32'(bus.arready), 32'd1);

        // Reset in the middle of a write data beat: nothing is written.
        bus.awid = 4'h5; bus.awaddr = 32'h500; bus.awsize = 3'd2; bus.awlen = 8'd1;
        bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b1; bus.wdata = 32'h7777_7777; bus.wstrb = 4'hF; bus.wlast = 1'b0;
        #1;
        chk("wr_abort_ram_en_pre", 32'(ram_en), 32'd1);
        resetn = 1'b0;
        #1;
        chk("wr_abort_outputs_zero", 32'(any_out()), 32'd0);
        bus.wvalid = 1'b0;
        step();
        resetn = 1'b1;
        #1;
        chk("wr_abort_run_gate", 32'(bus.awready), 32'd0);
        step();
        chk("wr_abort_awready_back", 32'(bus.awready), 32'd1);
        exp_q.push_back(32'h11AD_BEEF);
        axi_read(4'h7, 32'h100, 3'd2, 0, BURST_INCR, 1'b0);
        exp_q.push_back(32'h0BAD_F00D);
        axi_read(4'h8, 32'h500, 3'd2, 0, BURST_INCR, 1'b0);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
